bitwise_op_pipe: RTL

BITWISE_OP_PIPE -- requirements
Module: bitwise_op_pipe

---
 rtl/bitwise_op_pkg.sv | 15 +
 rtl/bitwise_pipe_stage.sv | 45 ++++
 rtl/bitwise_op_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bitwise_op_pkg.sv
// Shared definitions for the bitwise reduction pipeline.
//   op_e      : per-transaction operation code carried alongside the operands
//   CntWidth  : width of the output-transfer counter
package bitwise_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } op_e;

  localparam int unsigned CntWidth = 16;

endpackage

// File: rtl/bitwise_pipe_stage.sv
// One valid/data register stage of the result pipeline. The parent decides when the stage
// loads; on load it captures the upstream valid bit and, for a valid beat, the result and
// its zero flag.
//   clk, reset         : clock, synchronous active-high reset
//   i_load             : stage captures upstream this edge
//   i_valid/i_data/i_zero : upstream beat
//   o_valid/o_data/o_zero : registered beat held by this stage
module bitwise_pipe_stage #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_zero,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_zero
);

  logic             r_valid = 1'b0;
  logic [WIDTH-1:0] r_data  = '0;
  logic             r_zero  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      // Payload only moves with a valid beat; it is don't-care otherwise.
      if (i_valid) begin
        r_data <= i_data;
        r_zero <= i_zero;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_zero  = r_zero;

endmodule

// File: rtl/bitwise_op_pipe.sv
// Valid/ready pipeline that reduces NUM_IN operands bitwise (AND/OR/XOR/NAND) to one result.
// Stage 1 registers the operands and op; the reduction feeds STAGES-1 result stages, the
// last of which drives the outputs directly from registers.
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake
//   in_data               : NUM_IN operands, operand i at [i*WIDTH +: WIDTH]
//   in_op                 : 0 AND, 1 OR, 2 XOR, 3 NAND
//   out_valid/out_ready   : output handshake
//   out_data, out_zero    : result and its all-zeros flag
//   xfer_count            : saturating count of output transfers
module bitwise_op_pipe
  import bitwise_op_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic [CntWidth-1:0]     xfer_count
);

  localparam int unsigned NumPipe = STAGES - 1;

  // Stage 1: operands and op captured together.
  logic                    r_s1_valid = 1'b0;
  logic [NUM_IN*WIDTH-1:0] r_s1_data  = '0;
  op_e                     r_s1_op    = OP_AND;
  logic [CntWidth-1:0]     r_xfer_count = '0;

  logic                            w_s1_load;
  logic [WIDTH-1:0]                w_and, w_or, w_xor, w_red;
  logic                            w_red_zero;
  logic [NumPipe-1:0]              w_load;
  logic [NumPipe-1:0]              w_in_v, w_pv, w_in_z, w_pz;
  logic [NumPipe-1:0][WIDTH-1:0]   w_in_d, w_pd;

  // A stage loads if it or any later stage is empty, or the output is being taken: the
  // recursive "empty or next loads" rule unrolled, so no signal feeds back on itself.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int j = int'(NumPipe) - 1; j >= 0; j--) begin
      acc       = acc | ~w_pv[j];
      w_load[j] = acc;
    end
  end

  assign w_s1_load = ~r_s1_valid | w_load[0];
  assign in_ready  = w_s1_load & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_op    <= OP_AND;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= in_data;
        r_s1_op   <= op_e'(in_op);
      end
    end
  end

  // Reduction of the registered operands.
  always_comb begin
    w_and = r_s1_data[WIDTH-1:0];
    w_or  = r_s1_data[WIDTH-1:0];
    w_xor = r_s1_data[WIDTH-1:0];
    for (int i = 1; i < int'(NUM_IN); i++) begin
      w_and = w_and & r_s1_data[i*WIDTH +: WIDTH];
      w_or  = w_or  | r_s1_data[i*WIDTH +: WIDTH];
      w_xor = w_xor ^ r_s1_data[i*WIDTH +: WIDTH];
    end
    case (r_s1_op)
      OP_AND:  w_red = w_and;
      OP_OR:   w_red = w_or;
      OP_XOR:  w_red = w_xor;
      OP_NAND: w_red = ~w_and;
      default: w_red = w_and;
    endcase
  end

  assign w_red_zero = (w_red == '0);

  // Chain the result stages: stage 0 takes the reduction, the rest take their predecessor.
  always_comb begin
    w_in_v[0] = r_s1_valid;
    w_in_d[0] = w_red;
    w_in_z[0] = w_red_zero;
    for (int j = 1; j < int'(NumPipe); j++) begin
      w_in_v[j] = w_pv[j-1];
      w_in_d[j] = w_pd[j-1];
      w_in_z[j] = w_pz[j-1];
    end
  end

  for (genvar j = 0; j < int'(NumPipe); j++) begin : g_stage
    bitwise_pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load[j]),
      .i_valid (w_in_v[j]),
      .i_data  (w_in_d[j]),
      .i_zero  (w_in_z[j]),
      .o_valid (w_pv[j]),
      .o_data  (w_pd[j]),
      .o_zero  (w_pz[j])
    );
  end

  assign out_valid = w_pv[NumPipe-1];
  assign out_data  = w_pd[NumPipe-1];
  assign out_zero  = w_pz[NumPipe-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (out_valid && out_ready && (r_xfer_count != '1)) begin
      r_xfer_count <= r_xfer_count + CntWidth'(1);
    end
  end

  assign xfer_count = r_xfer_count;

endmodule
